sum_to_count: RTL
=================

Name: sum_to_count

Overview:
- Inverse of the sum1to100 accumulator: given a sum S, finds the largest n with 1+2+…+n ≤ S, and reports n and the leftover S − n(n+1)/2.
- Works by subtracting 1, 2, 3, … serially from S, one term per clock.
- Sits downstream of sum1to100 or any triangular-sum source and shares its start/finish handshake style.
- Typical use: self-check that sum1to100 result 5050 decodes back to n=100 with zero remainder.

Parameters:
- SW, 13, width of the sum input (matches the sum1to100 result width).
- NW, 7, width of count and remainder outputs. Must satisfy 2^NW·(2^NW+1)/2 > 2^SW − 1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a decode. Sampled only in IDLE or DONE.
- sum_in  input  SW  sum to decode, unsigned. Latched on the edge that accepts start.
- count  output  NW  largest n with n(n+1)/2 ≤ sum_in.
- remainder  output  NW  sum_in − count(count+1)/2. Always ≤ count.
- exact  output  1  1 when remainder == 0.
- busy  output  1  1 while in RUN.
- finish  output  1  1 while in DONE; results valid.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, and count, remainder, exact, busy, finish all 0. Internal acc, k and cnt are cleared. Reset wins over start.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch acc=sum_in, k=1, cnt=0, then go to RUN with busy=1.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - If acc ≥ k: acc = acc − k, cnt = k, k = k + 1.
  - Else: count=cnt, remainder=acc, exact=(acc==0), busy=0, finish=1, go to DONE.
- RUN ignores start and sum_in; they have no effect until DONE.
- DONE:
  - count, remainder, exact and finish hold indefinitely.
  - On start=1: clear finish, latch the new sum_in, re-enter RUN.
- Widths:
  - acc is SW bits.
  - k is NW+1 bits, so it can reach 2^NW without wrapping.
  - Comparison and subtraction are unsigned. acc never underflows.
- Latency: with the start edge as E0, finish rises at edge E0+n+1, where n is the final count. S=0 gives finish at E0+1.
- Worst case at defaults: S=8191 gives n=127, so finish at E0+128.
- Outputs change only on the edge entering DONE, on restart (finish only), or on reset.
- Reset mid-RUN: the computation is abandoned, and the next edge after rst falls behaves as IDLE.

Test Plan:
- rst=1 for 2 cycles, then rst=0 with start=0 → count=0, remainder=0, exact=0, busy=0, finish=0. The block stays in IDLE.
- sum_in=5050, start pulse at E0 → busy=1 during edges E0..E0+100; finish=1 at E0+101 with count=100, remainder=0, exact=1. Outputs hold for 20 further cycles.
- sum_in=0 → finish at E0+1 with count=0, remainder=0, exact=1.
- sum_in=8191 → count=127, remainder=63, exact=0, finish at E0+128. sum_in=5051 → count=100, remainder=1, exact=0.
- sum_in=4 started from DONE; sum_in changed to 9 and start toggled during RUN → count=2, remainder=1, finish at E0+3. The changes during RUN are ignored.
- rst=1 asserted at E0+40 of a 5050 decode → all outputs 0 at the next edge. A new start with sum_in=10 then gives count=4, remainder=0, exact=1 at E0'+5.

Source files
------------

// File: rtl/sum_to_count.sv
// Serial triangular-sum decoder: subtracts 1, 2, 3, ... from the latched sum
// one term per clock, reporting the largest n with n(n+1)/2 <= sum and the leftover.
module sum_to_count #(
  parameter int SW = 13,
  parameter int NW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] sum_in,
  output logic [NW-1:0] count,
  output logic [NW-1:0] remainder,
  output logic          exact,
  output logic          busy,
  output logic          finish
);

  // Common width for comparing the accumulator against the next term.
  localparam int CW = (SW > NW + 1) ? SW : NW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg;
  logic [SW-1:0] acc_reg;
  logic [NW:0]   k_reg;
  logic [NW-1:0] cnt_reg;
  logic          take_term;

  assign take_term = CW'(acc_reg) >= CW'(k_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      k_reg     <= '0;
      cnt_reg   <= '0;
      count     <= '0;
      remainder <= '0;
      exact     <= 1'b0;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            acc_reg   <= sum_in;
            k_reg     <= (NW + 1)'(1);
            cnt_reg   <= '0;
            busy      <= 1'b1;
            finish    <= 1'b0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (take_term) begin
            // acc >= k here, so the subtraction cannot underflow.
            acc_reg <= acc_reg - SW'(k_reg);
            cnt_reg <= k_reg[NW-1:0];
            k_reg   <= k_reg + 1'b1;
          end else begin
            // Leftover is below k = count+1, so it always fits in NW bits.
            count     <= cnt_reg;
            remainder <= acc_reg[NW-1:0];
            exact     <= (acc_reg == '0);
            busy      <= 1'b0;
            finish    <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
